updown_led_counter: RTL and testbench
=====================================

# updown_led_counter

Parametrised free-running LED counter with up, down, bounce and hold modes, a clock prescaler, synchronous load, and a one-cycle wrap/reversal pulse. It drives a board LED bank from the top bits of a wide counter. It generalises the fixed 30-bit up/down LED counter to arbitrary counter/LED widths, a programmable count rate and direction-reversing operation.

## Interface
Parameters:
- `CNT_W`, default 30: counter width in bits; minimum 2.
- `LED_W`, default 8: LED output width; 1 ≤ LED_W ≤ CNT_W.
- `DIV`, default 1: prescaler divide ratio; counter steps once per DIV enabled cycles; minimum 1.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `srst`, input, 1: reset, asynchronous and active-high.
- `en`, input, 1: count enable; gates the prescaler.
- `mode`, input, 2: 00 up, 01 down, 10 bounce, 11 hold.
- `load`, input, 1: synchronous load strobe.
- `load_val`, input, CNT_W: value written on `load`.
- `led`, output, LED_W: `cnt[CNT_W-1 -: LED_W]`.
- `dir`, output, 1: current direction state; 0 = UP, 1 = DOWN.
- `wrap`, output, 1: registered one-cycle pulse on wrap or bounce reversal.

## Operation
- Internal state:
  - `cnt[CNT_W-1:0]`.
  - Prescaler `presc` in 0..DIV-1.
  - Direction FSM with states UP and DOWN.
  - `wrap` register.
- Reset (`srst`=1, asynchronous): `cnt`=0, `presc`=0, FSM=UP, `wrap`=0. Therefore `led`=0 and `dir`=0. Reset asserted mid-count clears everything immediately, with no clock needed.
- Priority per cycle: `srst` > `load` > tick step.
- `load`=1:
  - `cnt`←`load_val`, `presc`←0, FSM←UP, `wrap`←0.
  - `load` applies regardless of `en` and `mode`, including mode 11.
- Prescaler:
  - Advances only when `en`=1 and `mode`≠11.
  - `tick` = advance condition AND `presc`==DIV-1.
  - On `tick`, `presc`←0; otherwise `presc`←`presc`+1.
  - With DIV=1, `tick` is asserted on every enabled cycle.
  - When `en`=0 or `mode`=11, `presc` holds its value (it is not cleared).
- On `tick`, by mode:
  - Mode 00: FSM←UP. `cnt`←`cnt`+1 modulo 2^CNT_W. `wrap`←1 iff `cnt` was MAX (all ones).
  - Mode 01: FSM←DOWN. `cnt`←`cnt`-1 modulo 2^CNT_W. `wrap`←1 iff `cnt` was 0.
  - Mode 10, FSM in UP: if `cnt`==MAX, then FSM←DOWN, `cnt`←MAX-1, `wrap`←1; else `cnt`+1.
  - Mode 10, FSM in DOWN: if `cnt`==0, then FSM←UP, `cnt`←1, `wrap`←1; else `cnt`-1.
  - Mode 10 continues from the current FSM state. Switching 00→10 therefore starts bouncing upward; 01→10 starts downward.
  - Mode 11: no tick occurs; `cnt`, `presc` and FSM hold.
- `wrap`←0 on every cycle not described above as setting it.
- `mode` is sampled on every cycle. A mode change takes effect on the next tick with no flush.

## Timing
- All state is registered on the rising edge of `clk`.
- `led` and `dir` are combinational from registers, so they change on the same edge as `cnt` and the FSM.
- `wrap` is high for exactly one cycle, starting at the edge that performs the wrapping or reversing update.
- Load latency: 1 edge. The new value is visible on `led` after the edge where `load`=1.
- Count rate: one step per DIV enabled cycles. The first tick after reset or load occurs on the DIV-th enabled edge.
- `load` and `tick` in the same cycle: the load wins, and that tick is discarded.
- `srst` released asynchronously: the first counting edge is the next rising `clk` edge with `en`=1. The integrator is responsible for synchronising deassertion.

## Configuration
- Macro `UPDOWN_LED_COUNTER_SATURATE_EN`.
- Defined:
  - Mode 00 at MAX holds at MAX.
  - Mode 01 at 0 holds at 0.
  - `wrap` is never asserted in modes 00 and 01.
  - Modes 10 and 11 are unchanged.
- Undefined (default): modular wrap with a `wrap` pulse, as described in Operation.

## Test plan
Bench parameters: CNT_W=4, LED_W=2, DIV=3 unless stated otherwise.
- Reset and rate: assert `srst` mid-count with no clock edge → `led`=0, `dir`=0 and `wrap`=0 immediately. Then `en`=1, `mode`=00 → `cnt` reaches 1 after 3 edges and 5 after 15 edges; `led`=01 once `cnt`=4.
- Up wrap: load 14, then `mode`=00, `en`=1 → `cnt` goes 15 then 0. `wrap`=1 for one cycle, coincident with the 15→0 update.
- Down wrap and enable gating: load 1, `mode`=01 → 1, 0, 15 with `wrap` pulsing on the 0→15 update. Drop `en` for 5 cycles → `cnt` and `presc` frozen; counting resumes with no extra delay.
- Bounce, DIV=1: load 13, `mode`=10 → 13, 14, 15, 14, 13. `dir` goes 0→1 on the 15→14 step, with `wrap` asserted on that same edge. Load 1, `mode`=01 for one tick (`cnt` becomes 0), then `mode`=10 → 0, 1, 2 with `dir`=0 and one `wrap` pulse.
- Load priority and hold: `load`=1 with `load_val`=9 on a tick cycle → `cnt`=9, `presc`=0, `dir`=0. Then `mode`=11 for 10 cycles → `cnt` stays at 9.
- With `UPDOWN_LED_COUNTER_SATURATE_EN` defined: load 14, `mode`=00 → 15, 15, 15, and `wrap` never asserts. Load 1, `mode`=01 → 0, 0, with no `wrap`.

Source files
------------

// File: rtl/updown_led_counter_if.sv
// -----------------------------------------------------------------------------
// updown_led_counter_if
//
// Purpose: groups the control and status signals of updown_led_counter so the
// counter and whatever drives it share one bundle. clk and srst are not part
// of the bundle; they stay plain ports on the counter.
//
// Parameters:
//   CNT_W  counter width in bits (>= 2)
//   LED_W  LED bank width (1..CNT_W)
//   DIV    prescaler divide ratio (>= 1); sets the width of presc_dbg
//
// Signals (direction as seen from the counter, i.e. the slave modport):
//   en        in   count enable, gates the prescaler
//   mode      in   2'b00 up, 2'b01 down, 2'b10 bounce, 2'b11 hold
//   load      in   synchronous load strobe
//   load_val  in   value written into the counter on load
//   led       out  top LED_W bits of the counter
//   dir       out  direction state, 0 = UP, 1 = DOWN
//   wrap      out  registered one-cycle pulse on wrap or bounce reversal
//   cnt_dbg   out  full counter value, for observation only
//   presc_dbg out  prescaler phase, for observation only
//
// Modports: master drives the controls, slave is the counter itself.
// -----------------------------------------------------------------------------
interface updown_led_counter_if #(
   parameter int CNT_W = 30,
   parameter int LED_W = 8,
   parameter int DIV   = 1
);
   // A divide-by-one prescaler still gets a one-bit register so no signal
   // ends up zero width.
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic             en;
   logic [1:0]       mode;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic [LED_W-1:0] led;
   logic             dir;
   logic             wrap;
   logic [CNT_W-1:0] cnt_dbg;
   logic [PW-1:0]    presc_dbg;

   modport master (
      output en,
      output mode,
      output load,
      output load_val,
      input  led,
      input  dir,
      input  wrap,
      input  cnt_dbg,
      input  presc_dbg
   );

   modport slave (
      input  en,
      input  mode,
      input  load,
      input  load_val,
      output led,
      output dir,
      output wrap,
      output cnt_dbg,
      output presc_dbg
   );
endinterface : updown_led_counter_if

// File: rtl/updown_led_counter.sv
// -----------------------------------------------------------------------------
// updown_led_counter
//
// Purpose: free-running LED counter with up, down, bounce and hold modes, a
// clock prescaler, a synchronous load and a one-cycle wrap/reversal pulse.
// The LED bank shows the top LED_W bits of a CNT_W-bit counter.
//
// Parameters:
//   CNT_W  counter width in bits, minimum 2            (default 30)
//   LED_W  LED output width, 1 <= LED_W <= CNT_W       (default 8)
//   DIV    counter steps once per DIV enabled cycles   (default 1)
//
// Ports:
//   clk   rising-edge clock for all state
//   srst  asynchronous, active-high reset
//   bus   updown_led_counter_if.slave:
//           en, mode, load, load_val  -> controls
//           led, dir, wrap            -> outputs
//           cnt_dbg, presc_dbg        -> state observation
//
// Handshake: there is no valid/ready flow here. Every input is sampled on
// every rising clk edge; load has priority over counting and reset has
// priority over everything, asynchronously.
//
// Build option: define UPDOWN_LED_COUNTER_SATURATE_EN to make modes 00 and 01
// saturate at MAX and 0 instead of wrapping (no wrap pulse in those modes).
// Bounce and hold behave the same either way. Default build: wrap around.
// -----------------------------------------------------------------------------
module updown_led_counter #(
   parameter int CNT_W = 30,
   parameter int LED_W = 8,
   parameter int DIV   = 1
) (
   input  logic                  clk,
   input  logic                  srst,
   updown_led_counter_if.slave   bus
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   // Direction FSM. The encoding doubles as the dir output bit.
   typedef enum logic {
      ST_UP   = 1'b0,
      ST_DOWN = 1'b1
   } state_e;

   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [PW-1:0]    presc_q, presc_d;
   state_e           state_q, state_d;
   logic             wrap_q,  wrap_d;

   logic             advance;
   logic             tick;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      cnt_d   = cnt_q;
      presc_d = presc_q;
      state_d = state_q;
      wrap_d  = 1'b0;

      // Hold mode freezes the prescaler phase as well as the counter, so
      // leaving hold resumes mid-period rather than restarting the period.
      advance = bus.en && (bus.mode != MODE_HOLD);
      tick    = advance && (presc_q == PRESC_LAST);

      if (bus.load) begin
         // A load restarts the prescaler period and points the FSM up; a
         // tick falling on the same cycle is simply lost.
         cnt_d   = bus.load_val;
         presc_d = '0;
         state_d = ST_UP;
      end else if (advance) begin
         presc_d = tick ? '0 : (presc_q + PRESC_ONE);

         if (tick) begin
            case (bus.mode)
               MODE_UP: begin
                  state_d = ST_UP;
                  if (cnt_q == CNT_MAX) begin
`ifdef UPDOWN_LED_COUNTER_SATURATE_EN
                     cnt_d  = CNT_MAX;
`else
                     cnt_d  = CNT_ZERO;
                     wrap_d = 1'b1;
`endif
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end

               MODE_DOWN: begin
                  state_d = ST_DOWN;
                  if (cnt_q == CNT_ZERO) begin
`ifdef UPDOWN_LED_COUNTER_SATURATE_EN
                     cnt_d  = CNT_ZERO;
`else
                     cnt_d  = CNT_MAX;
                     wrap_d = 1'b1;
`endif
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end

               MODE_BOUNCE: begin
                  // Bounce carries on in whatever direction the FSM already
                  // holds; the end values are visited once, then the count
                  // turns around in the same step.
                  if (state_q == ST_UP) begin
                     if (cnt_q == CNT_MAX) begin
                        state_d = ST_DOWN;
                        cnt_d   = CNT_MAX - CNT_ONE;
                        wrap_d  = 1'b1;
                     end else begin
                        cnt_d = cnt_q + CNT_ONE;
                     end
                  end else begin
                     if (cnt_q == CNT_ZERO) begin
                        state_d = ST_UP;
                        cnt_d   = CNT_ONE;
                        wrap_d  = 1'b1;
                     end else begin
                        cnt_d = cnt_q - CNT_ONE;
                     end
                  end
               end

               default: begin
                  // Hold never advances, so no tick reaches this branch.
               end
            endcase
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         cnt_q   <= '0;
         presc_q <= '0;
         state_q <= ST_UP;
         wrap_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         state_q <= state_d;
         wrap_q  <= wrap_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs: all taken straight from registers.
   // --------------------------------------------------------------------------
   assign bus.led       = cnt_q[CNT_W-1 -: LED_W];
   assign bus.dir       = (state_q == ST_DOWN);
   assign bus.wrap      = wrap_q;
   assign bus.cnt_dbg   = cnt_q;
   assign bus.presc_dbg = presc_q;

endmodule : updown_led_counter

// File: tb/tb_updown_led_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_led_counter
//
// Two counters with CNT_W=4, LED_W=2 are driven from the same inputs: index 0
// has DIV=3, index 1 has DIV=1. A reference model built from plain integer
// arithmetic tracks both and is compared with every output on each falling
// edge. Directed sequences with hand-computed values come first, then a long
// randomized run with occasional asynchronous reset pulses.
// -----------------------------------------------------------------------------
module tb_updown_led_counter;

   localparam int CNT_W = 4;
   localparam int LED_W = 2;
   localparam int MAXV  = 15;

`ifdef UPDOWN_LED_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // ---------------------------------------------------------------- clock/reset
   logic clk  = 1'b0;
   logic srst = 1'b1;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- stimulus
   logic             en       = 1'b0;
   logic [1:0]       mode     = 2'b00;
   logic             load     = 1'b0;
   logic [CNT_W-1:0] load_val = '0;

   updown_led_counter_if #(.CNT_W(CNT_W), .LED_W(LED_W), .DIV(3)) bus3 ();
   updown_led_counter_if #(.CNT_W(CNT_W), .LED_W(LED_W), .DIV(1)) bus1 ();

   assign bus3.en = en;  assign bus3.mode = mode;
   assign bus3.load = load;  assign bus3.load_val = load_val;
   assign bus1.en = en;  assign bus1.mode = mode;
   assign bus1.load = load;  assign bus1.load_val = load_val;

   updown_led_counter #(.CNT_W(CNT_W), .LED_W(LED_W), .DIV(3)) u_dut3 (
      .clk  (clk),
      .srst (srst),
      .bus  (bus3)
   );

   updown_led_counter #(.CNT_W(CNT_W), .LED_W(LED_W), .DIV(1)) u_dut1 (
      .clk  (clk),
      .srst (srst),
      .bus  (bus1)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int   div_a [2] = '{3, 1};
   int   m_cnt [2];
   int   m_presc [2];
   bit   m_down [2];
   bit   m_wrap [2];

   always @(posedge clk or posedge srst) begin
      int c;
      for (int k = 0; k < 2; k++) begin
         c = m_cnt[k];
         if (srst) begin
            m_cnt[k] <= 0; m_presc[k] <= 0; m_down[k] <= 1'b0; m_wrap[k] <= 1'b0;
         end else if (load) begin
            m_cnt[k] <= int'(load_val); m_presc[k] <= 0; m_down[k] <= 1'b0; m_wrap[k] <= 1'b0;
         end else begin
            m_wrap[k] <= 1'b0;
            if (en && mode != 2'b11) begin
               if (m_presc[k] == div_a[k] - 1) begin
                  m_presc[k] <= 0;
                  if (mode == 2'b00) begin
                     m_down[k] <= 1'b0;
                     if (c == MAXV && SAT) m_cnt[k] <= MAXV;
                     else begin
                        m_cnt[k]  <= (c + 1) % (MAXV + 1);
                        m_wrap[k] <= (c == MAXV);
                     end
                  end else if (mode == 2'b01) begin
                     m_down[k] <= 1'b1;
                     if (c == 0 && SAT) m_cnt[k] <= 0;
                     else begin
                        m_cnt[k]  <= (c + MAXV) % (MAXV + 1);
                        m_wrap[k] <= (c == 0);
                     end
                  end else if (!m_down[k]) begin
                     if (c == MAXV) begin
                        m_down[k] <= 1'b1; m_cnt[k] <= MAXV - 1; m_wrap[k] <= 1'b1;
                     end else m_cnt[k] <= c + 1;
                  end else begin
                     if (c == 0) begin
                        m_down[k] <= 1'b0; m_cnt[k] <= 1; m_wrap[k] <= 1'b1;
                     end else m_cnt[k] <= c - 1;
                  end
               end else begin
                  m_presc[k] <= m_presc[k] + 1;
               end
            end
         end
      end
   end

   // Continuous comparison on every falling edge outside reset.
   always @(negedge clk) begin
      if (!srst) begin
         check("led",   0, 32'(bus3.led),       32'(m_cnt[0] / 4));
         check("dir",   0, 32'(bus3.dir),       32'(m_down[0]));
         check("wrap",  0, 32'(bus3.wrap),      32'(m_wrap[0]));
         check("cnt",   0, 32'(bus3.cnt_dbg),   32'(m_cnt[0]));
         check("presc", 0, 32'(bus3.presc_dbg), 32'(m_presc[0]));
         check("led",   1, 32'(bus1.led),       32'(m_cnt[1] / 4));
         check("dir",   1, 32'(bus1.dir),       32'(m_down[1]));
         check("wrap",  1, 32'(bus1.wrap),      32'(m_wrap[1]));
         check("cnt",   1, 32'(bus1.cnt_dbg),   32'(m_cnt[1]));
         check("presc", 1, 32'(bus1.presc_dbg), 32'(m_presc[1]));
      end
   end

   // ---------------------------------------------------------------- driver
   // Inputs set before cyc() are sampled at its rising edge; cyc() returns
   // 1 ns later, when registered outputs have settled.
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input int v, input logic [1:0] m);
      load = 1'b1; load_val = CNT_W'(v); mode = m;
      cyc();
      load = 1'b0;
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      // Reset state.
      cyc(2);
      check("rst_led",  0, 32'(bus3.led),  0);
      check("rst_dir",  0, 32'(bus3.dir),  0);
      check("rst_wrap", 0, 32'(bus3.wrap), 0);
      srst = 1'b0;

      // Rate: DIV=3 reaches 1 after 3 edges and 5 after 15; DIV=1 reaches 15.
      en = 1'b1; mode = 2'b00;
      cyc(3);
      check("rate_cnt1",   0, 32'(bus3.cnt_dbg), 1);
      check("model_cnt1",  0, 32'(m_cnt[0]),     1);
      cyc(12);
      check("rate_cnt5",   0, 32'(bus3.cnt_dbg), 5);
      check("rate_led1",   0, 32'(bus3.led),     1);
      check("rate_cnt15",  1, 32'(bus1.cnt_dbg), 15);

      // Asynchronous reset mid-count, away from any rising edge.
      #1 srst = 1'b1;
      #1;
      check("arst_led",  0, 32'(bus3.led),     0);
      check("arst_dir",  0, 32'(bus3.dir),     0);
      check("arst_wrap", 0, 32'(bus3.wrap),    0);
      check("arst_cnt",  1, 32'(bus1.cnt_dbg), 0);
      #1 srst = 1'b0;
      cyc();

      // Up wrap on DIV=3.
      do_load(14, 2'b00);
      check("upw_load", 0, 32'(bus3.cnt_dbg), 14);
      cyc(3);
      check("upw_15",   0, 32'(bus3.cnt_dbg), 15);
      check("upw_nw",   0, 32'(bus3.wrap),    0);
      cyc(3);
      check("upw_0",    0, 32'(bus3.cnt_dbg), SAT ? 15 : 0);
      check("upw_wrap", 0, 32'(bus3.wrap),    SAT ? 0 : 1);
      cyc();
      check("upw_end",  0, 32'(bus3.wrap),    0);

      // Down wrap and enable gating on DIV=3.
      do_load(1, 2'b01);
      cyc(3);
      check("dnw_0",    0, 32'(bus3.cnt_dbg), 0);
      check("dnw_dir",  0, 32'(bus3.dir),     1);
      cyc(3);
      check("dnw_15",   0, 32'(bus3.cnt_dbg), SAT ? 0 : 15);
      check("dnw_wrap", 0, 32'(bus3.wrap),    SAT ? 0 : 1);
      cyc();
      en = 1'b0;
      cyc(5);
      check("gate_cnt",   0, 32'(bus3.cnt_dbg),   SAT ? 0 : 15);
      check("gate_presc", 0, 32'(bus3.presc_dbg), 1);
      en = 1'b1;
      cyc();
      check("gate_hold", 0, 32'(bus3.cnt_dbg), SAT ? 0 : 15);
      cyc();
      check("gate_step", 0, 32'(bus3.cnt_dbg), SAT ? 0 : 14);

      // Bounce on DIV=1: 13, 14, 15, 14, 13.
      do_load(13, 2'b10);
      cyc();
      check("bnc_14", 1, 32'(bus1.cnt_dbg), 14);
      cyc();
      check("bnc_15", 1, 32'(bus1.cnt_dbg), 15);
      check("bnc_d0", 1, 32'(bus1.dir),     0);
      cyc();
      check("bnc_r14",  1, 32'(bus1.cnt_dbg), 14);
      check("bnc_d1",   1, 32'(bus1.dir),     1);
      check("bnc_wrap", 1, 32'(bus1.wrap),    1);
      cyc();
      check("bnc_13",  1, 32'(bus1.cnt_dbg), 13);
      check("bnc_nw",  1, 32'(bus1.wrap),    0);

      // Down one tick to 0, then bounce upward from the DOWN state: 0, 1, 2.
      do_load(1, 2'b01);
      cyc();
      check("bnc2_0", 1, 32'(bus1.cnt_dbg), 0);
      mode = 2'b10;
      cyc();
      check("bnc2_1",    1, 32'(bus1.cnt_dbg), 1);
      check("bnc2_dir",  1, 32'(bus1.dir),     0);
      check("bnc2_wrap", 1, 32'(bus1.wrap),    1);
      cyc();
      check("bnc2_2",  1, 32'(bus1.cnt_dbg), 2);
      check("bnc2_nw", 1, 32'(bus1.wrap),    0);

      // Load on a tick cycle of DIV=3 while counting down, then hold.
      do_load(3, 2'b01);
      cyc(3);
      check("lp_pre_cnt", 0, 32'(bus3.cnt_dbg), 2);
      check("lp_pre_dir", 0, 32'(bus3.dir),     1);
      cyc(2);
      check("lp_pre_presc", 0, 32'(bus3.presc_dbg), 2);
      do_load(9, 2'b01);
      check("lp_cnt",   0, 32'(bus3.cnt_dbg),   9);
      check("lp_presc", 0, 32'(bus3.presc_dbg), 0);
      check("lp_dir",   0, 32'(bus3.dir),       0);
      mode = 2'b00;
      cyc();
      mode = 2'b11;
      cyc(10);
      check("hold_cnt",   0, 32'(bus3.cnt_dbg),   9);
      check("hold_presc", 0, 32'(bus3.presc_dbg), 1);

      // Randomized run.
      for (int i = 0; i < 2000; i++) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
         load     = ($urandom_range(0, 31) == 0);
         load_val = CNT_W'($urandom_range(0, MAXV));
         if ($urandom_range(0, 299) == 0) begin
            #1 srst = 1'b1;
            #1 srst = 1'b0;
         end
         cyc();
      end
      load = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_updown_led_counter
